// File: rtl/link_receiver.sv
// link_receiver: serial link receive stage with framing check and receive FIFO.
// Deserializes S_IN (MSB first) into words framed by the SYNC pulse, which
// coincides with the last bit of each word, and queues them for game logic.
//
// Ports:
//   LINK_CLK  in   link clock (shared with the serializer)
//   RESETN    in   synchronous active-low reset
//   S_IN      in   serial data, first bit = RX_DATA[0]
//   SYNC      in   one-cycle pulse on the last bit of a word
//   RX_DATA   out  head-of-FIFO word, [0:DATA_WIDTH-1] ordering
//   RX_VALID  out  FIFO non-empty
//   RX_ACK    in   pop head word (ignored while RX_VALID=0)
//   RX_LEVEL  out  FIFO occupancy 0..FIFO_DEPTH
//   FRAME_ERR out  sticky: SYNC arrived before MIN_BITS quiet cycles
//   OVERFLOW  out  sticky: valid word dropped on a full FIFO
//   CLR_ERR   in   clear both sticky flags (a new error wins)
module link_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_BITS   = 15
) (
  input  logic                            LINK_CLK,
  input  logic                            RESETN,
  input  logic                            S_IN,
  input  logic                            SYNC,
  output logic [0:DATA_WIDTH-1]           RX_DATA,
  output logic                            RX_VALID,
  input  logic                            RX_ACK,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] RX_LEVEL,
  output logic                            FRAME_ERR,
  output logic                            OVERFLOW,
  input  logic                            CLR_ERR
);

  localparam int GAP_W = 5;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);

  localparam logic [GAP_W-1:0] GAP_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(MIN_BITS);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Datapath state
  logic [DATA_WIDTH-2:0] r_shift;
  logic [GAP_W-1:0]      r_gap;

  // FIFO state
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [LVL_W-1:0]      r_level;

  // Sticky flags
  logic r_frame_err;
  logic r_overflow;

  // Combinational control
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_sync_ok;
  logic                  w_frame;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // The word closes on the SYNC bit, so the current S_IN is its LSB.
  assign w_word = {r_shift, S_IN};

  assign w_sync_ok = SYNC && (r_gap >= GAP_MIN);
  assign w_frame   = SYNC && (r_gap <  GAP_MIN);

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_FULL);

  // A pop frees a slot this same edge, so a full FIFO still accepts
  // a push when it coincides with an ACK.
  assign w_pop  = RX_ACK && !w_empty;
  assign w_push = w_sync_ok && (!w_full || w_pop);
  assign w_drop = w_sync_ok && w_full && !w_pop;

  // Shift register and gap counter
  always_ff @(posedge LINK_CLK) begin
    if (!RESETN) begin
      r_shift <= '0;
      r_gap   <= '0;
    end else begin
      r_shift <= {r_shift[DATA_WIDTH-3:0], S_IN};
      if (SYNC)
        r_gap <= '0;
      else if (r_gap != GAP_MAX)
        r_gap <= r_gap + GAP_W'(1);
    end
  end

  // FIFO storage; cleared on reset so RX_DATA reads zero afterwards
  always_ff @(posedge LINK_CLK) begin
    if (!RESETN) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge LINK_CLK) begin
    if (!RESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags: a new error in the clear cycle keeps the flag set
  always_ff @(posedge LINK_CLK) begin
    if (!RESETN) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_frame | (r_frame_err & ~CLR_ERR);
      r_overflow  <= w_drop  | (r_overflow  & ~CLR_ERR);
    end
  end

  // Outputs; the MSB of the stored word is the first bit received
  assign RX_DATA   = r_mem[r_rptr];
  assign RX_VALID  = !w_empty;
  assign RX_LEVEL  = r_level;
  assign FRAME_ERR = r_frame_err;
  assign OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_link_receiver.sv
// tb_link_receiver: directed checks of link_receiver framing,
// FIFO ordering, overflow, sticky flags and reset.
module tb_link_receiver;

  logic        clk;
  logic        resetn;
  logic        s_in;
  logic        sync;
  logic [0:15] rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic [2:0]  rx_level;
  logic        frame_err;
  logic        overflow;
  logic        clr_err;

  int n_cmp;
  int n_err;

  link_receiver dut (
    .LINK_CLK  (clk),
    .RESETN    (resetn),
    .S_IN      (s_in),
    .SYNC      (sync),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .RX_ACK    (rx_ack),
    .RX_LEVEL  (rx_level),
    .FRAME_ERR (frame_err),
    .OVERFLOW  (overflow),
    .CLR_ERR   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      s_in   = 1'b0;
      sync   = 1'b0;
      rx_ack = ack;
      tick();
    end
    rx_ack = 1'b0;
  endtask

  // Sends the low n bits of w MSB first, SYNC on the last bit;
  // ack is driven only in the SYNC cycle.
  task automatic send_bits(input logic [15:0] w, input int n,
                           input logic ack);
    for (int i = n - 1; i >= 0; i--) begin
      s_in   = w[i];
      sync   = (i == 0);
      rx_ack = (i == 0) ? ack : 1'b0;
      tick();
    end
    s_in   = 1'b0;
    sync   = 1'b0;
    rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  logic [15:0] exp_q [4];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    resetn  = 1'b0;
    s_in    = 1'b0;
    sync    = 1'b0;
    rx_ack  = 1'b0;
    clr_err = 1'b0;
    tick();
    tick();
    chk("rst_valid", 16'(rx_valid), 16'd0);
    chk("rst_level", 16'(rx_level), 16'd0);
    chk("rst_data", 16'(rx_data), 16'h0000);
    chk("rst_ferr", 16'(frame_err), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    resetn = 1'b1;

    // Single word after idle
    idle(20, 1'b0);
    send_bits(16'hA5C3, 16, 1'b0);
    chk("w1_valid", 16'(rx_valid), 16'd1);
    chk("w1_data", 16'(rx_data), 16'hA5C3);
    chk("w1_bit0", 16'(rx_data[0]), 16'd1);
    chk("w1_level", 16'(rx_level), 16'd1);
    idle(1, 1'b1);
    chk("w1_pop_valid", 16'(rx_valid), 16'd0);
    chk("w1_pop_level", 16'(rx_level), 16'd0);

    // Minimum spacing, ACK on the SYNC cycle of an empty FIFO
    send_bits(16'h1234, 16, 1'b1);
    chk("s_1234", 16'(rx_data), 16'h1234);
    chk("s_1234_lvl", 16'(rx_level), 16'd1);
    idle(1, 1'b1);
    send_bits(16'hFFFF, 16, 1'b1);
    chk("s_ffff", 16'(rx_data), 16'hFFFF);
    idle(1, 1'b1);
    send_bits(16'h0001, 16, 1'b1);
    chk("s_0001", 16'(rx_data), 16'h0001);
    chk("s_0001_vld", 16'(rx_valid), 16'd1);
    idle(1, 1'b1);
    chk("s_empty", 16'(rx_level), 16'd0);
    chk("s_ferr", 16'(frame_err), 16'd0);
    chk("s_ovf", 16'(overflow), 16'd0);

    // Early SYNC -> framing error
    idle(1, 1'b0);
    send_bits(16'hBEEF, 16, 1'b0);
    send_bits(16'h00FF, 8, 1'b0);
    chk("fe_level", 16'(rx_level), 16'd1);
    chk("fe_flag", 16'(frame_err), 16'd1);
    chk("fe_data", 16'(rx_data), 16'hBEEF);
    pulse_clr();
    chk("fe_clr", 16'(frame_err), 16'd0);
    idle(1, 1'b1);
    chk("fe_drain", 16'(rx_level), 16'd0);

    // Overflow: five words with no ACK
    for (int k = 0; k < 5; k++) begin
      idle(1, 1'b0);
      send_bits(16'h1111 * 16'(k + 1), 16, 1'b0);
      if (k == 3)
        chk("of_pre", 16'(overflow), 16'd0);
    end
    chk("of_level", 16'(rx_level), 16'd4);
    chk("of_flag", 16'(overflow), 16'd1);
    chk("of_ferr", 16'(frame_err), 16'd0);
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("of_drain%0d", k), 16'(rx_data), exp_q[k]);
      idle(1, 1'b1);
    end
    chk("of_gone", 16'(rx_valid), 16'd0);
    pulse_clr();
    chk("of_clr", 16'(overflow), 16'd0);

    // Full FIFO, push coincident with pop
    for (int k = 0; k < 4; k++) begin
      idle(1, 1'b0);
      send_bits(16'h6001 + 16'(k), 16, 1'b0);
    end
    chk("fp_full", 16'(rx_level), 16'd4);
    idle(1, 1'b0);
    send_bits(16'h6005, 16, 1'b1);
    chk("fp_level", 16'(rx_level), 16'd4);
    chk("fp_ovf", 16'(overflow), 16'd0);
    exp_q = '{16'h6002, 16'h6003, 16'h6004, 16'h6005};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fp_drain%0d", k), 16'(rx_data), exp_q[k]);
      idle(1, 1'b1);
    end
    chk("fp_empty", 16'(rx_level), 16'd0);

    // Reset mid-word with data buffered and a flag set
    idle(1, 1'b0);
    send_bits(16'h7001, 16, 1'b0);
    idle(1, 1'b0);
    send_bits(16'h7002, 16, 1'b0);
    send_bits(16'h000A, 4, 1'b0);
    chk("mr_pre_lvl", 16'(rx_level), 16'd2);
    chk("mr_pre_fe", 16'(frame_err), 16'd1);
    for (int i = 0; i < 6; i++) begin
      s_in = i[0];
      tick();
    end
    s_in   = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mr_valid", 16'(rx_valid), 16'd0);
    chk("mr_level", 16'(rx_level), 16'd0);
    chk("mr_data", 16'(rx_data), 16'h0000);
    chk("mr_ferr", 16'(frame_err), 16'd0);
    chk("mr_ovf", 16'(overflow), 16'd0);
    send_bits(16'h0155, 10, 1'b0);
    chk("mr_early_fe", 16'(frame_err), 16'd1);
    chk("mr_early_lvl", 16'(rx_level), 16'd0);
    chk("mr_early_vld", 16'(rx_valid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/link_receiver.md
Name: link_receiver

Overview:
- Serial link receive stage, directly downstream of the 16-bit link serializer.
- Deserializes S_IN (MSB first) into 16-bit words, framed by the SYNC pulse that coincides with the last bit of each word.
- Buffers received words in a small FIFO with a valid/ack handshake for game logic.
- Flags framing errors and FIFO overflow.

Parameters:
- DATA_WIDTH, 16, word width; must equal the serializer block length.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2.
- MIN_BITS, 15, minimum SYNC-low cycles required since the previous SYNC (or since reset) for a word to be valid.

Ports:
- LINK_CLK  input  1  link clock, same clock as the serializer.
- RESETN  input  1  synchronous, active-low reset; sampled on posedge LINK_CLK.
- S_IN  input  1  serial data; bit 0 (MSB) first.
- SYNC  input  1  one-cycle pulse, high in the same cycle as the last bit (bit 15) on S_IN.
- RX_DATA  output  16  head-of-FIFO word, [0:15] ordering; bit 0 is the first bit received.
- RX_VALID  output  1  FIFO non-empty; RX_DATA is valid.
- RX_ACK  input  1  pop the head word; ignored when RX_VALID=0.
- RX_LEVEL  output  3  current FIFO occupancy, 0..FIFO_DEPTH.
- FRAME_ERR  output  1  sticky: a SYNC arrived too early.
- OVERFLOW  output  1  sticky: a word was dropped because the FIFO was full.
- CLR_ERR  input  1  clears FRAME_ERR and OVERFLOW.

Behaviour:
- Reset (RESETN=0 at a posedge) clears:
  - shift register and gap counter to 0;
  - FIFO pointers and level to 0;
  - RX_VALID=0, RX_DATA=0, RX_LEVEL=0, FRAME_ERR=0, OVERFLOW=0.
- Reset takes priority over every other event, including mid-word; a partial word is discarded.
- Shift register (15 bits): shifts S_IN in every cycle, new bit in the LSB.
- Word assembly: in a SYNC cycle, word = {shift_reg[14:0], S_IN}. The first bit received lands at RX_DATA[0].
- Gap counter (5 bits, saturating at 31):
  - loads 0 on a SYNC cycle;
  - increments otherwise.
- SYNC validity:
  - gap counter >= MIN_BITS: word is valid and is pushed.
  - gap counter < MIN_BITS: word is dropped and FRAME_ERR is set.
  - Either way, the gap counter restarts.
- Normal SYNC spacing is 17 cycles or more (gap counter = 16 at the next SYNC).
- The first SYNC after reset is valid only if at least 15 cycles have elapsed.
- Push timing: a valid word is written at the posedge ending the SYNC cycle. RX_VALID/RX_DATA reflect it in the following cycle (1-cycle latency when the FIFO was empty). There is no same-cycle bypass.
- Pop: RX_ACK=1 and RX_VALID=1 at a posedge advances the read pointer. RX_DATA is driven from FIFO memory at the read pointer.
- Full FIFO, valid push:
  - with a pop in the same cycle: push accepted, level unchanged, no overflow;
  - without a pop: word dropped, OVERFLOW set, FIFO contents untouched.
- Empty FIFO with push and RX_ACK in the same cycle: the ACK is ignored and the word is stored.
- Pointers wrap modulo FIFO_DEPTH. RX_LEVEL counts up/down and holds on a simultaneous push and pop.
- Sticky flags: CLR_ERR=1 clears both flags. If a new error occurs in the same cycle as CLR_ERR, the flag stays set (set wins).
- A framing error and an overflow cannot occur on the same SYNC: an invalid word is never pushed.

Test Plan:
- Reset, 20 idle cycles, shift 16'hA5C3 MSB first with SYNC on the 16th bit -> next cycle RX_VALID=1, RX_DATA=16'hA5C3, RX_LEVEL=1; RX_ACK=1 -> RX_VALID=0, RX_LEVEL=0.
- Words 16'h1234, 16'hFFFF, 16'h0001 at the minimum 17-cycle SYNC spacing, RX_ACK held 1 -> three words delivered in order, FRAME_ERR=0, OVERFLOW=0.
- Valid word, then SYNC only 8 cycles later -> second word not stored, RX_LEVEL stays 1, FRAME_ERR=1; pulse CLR_ERR -> FRAME_ERR=0.
- RX_ACK=0, five valid words -> RX_LEVEL=4, OVERFLOW=1; draining returns words 1-4 in order; the fifth is absent.
- FIFO full, valid SYNC coincident with RX_ACK=1 -> RX_LEVEL stays 4, OVERFLOW stays 0, the new word is last in the drain order.
- RESETN=0 for one cycle mid-word with 2 words buffered -> RX_VALID=0, RX_LEVEL=0, flags 0; a SYNC 10 cycles after reset -> FRAME_ERR=1, nothing stored.
